// File: rtl/vcpu_pkg.sv
// vcpu_pkg: opcodes, branch conditions and fetch FSM states shared by the vector CPU fetch controller
package vcpu_pkg;
  localparam logic [3:0] OP_COM = 4'hD;
  localparam logic [3:0] OP_B   = 4'hE;
  localparam logic [3:0] OP_END = 4'hF;
  typedef enum logic [1:0] {BR_AL, BR_Z, BR_NZ, BR_N} br_cond_t;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ACK, ISSUE, BR_WAIT, PAUSED, DONE} fetch_state_t;
endpackage

// File: rtl/vcpu_branch_eval.sv
// vcpu_branch_eval: resolves a branch condition against the latched {N,Z} flags
//   cond  : branch condition field of the instruction
//   flags : latched ALU flags {N,Z}
//   taken : branch is taken
module vcpu_branch_eval
  import vcpu_pkg::*;
(
  input  br_cond_t   cond,
  input  logic [1:0] flags,
  output logic       taken
);
  always_comb
    taken = (cond == BR_AL) ? 1'b1 : (cond == BR_Z) ? flags[0] : (cond == BR_NZ) ? !flags[0] : flags[1];
endmodule

// File: rtl/vcpu_fetch_ctrl.sv
// vcpu_fetch_ctrl: program-slot fetch/run controller with imem handshake, branch resolution and decode stall
//   clk, reset                 : clock, async active-high reset
//   start, pause, step, select : run control and program slot
//   imem_req/addr/ack/rdata    : instruction memory handshake
//   dec_stall, instr_d/vld     : decode interface
//   flags_we, alu_flags        : W-stage flag writeback
//   pipe_idle                  : nothing in flight past decode
//   pc, end_flag, com_flag     : status
module vcpu_fetch_ctrl
  import vcpu_pkg::*;
#(
  parameter int I = 32,
  parameter int NPROG = 4,
  parameter int SLOT_BITS = 10,
  localparam int SEL_W = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic [SEL_W-1:0] select,
  output logic             imem_req,
  output logic [I-1:0]     imem_addr,
  input  logic             imem_ack,
  input  logic [I-1:0]     imem_rdata,
  input  logic             dec_stall,
  output logic [I-1:0]     instr_d,
  output logic             instr_vld,
  input  logic             flags_we,
  input  logic [1:0]       alu_flags,
  input  logic             pipe_idle,
  output logic [I-1:0]     pc,
  output logic             end_flag,
  output logic             com_flag
);
  fetch_state_t state, n_state;
  logic [I-1:0] ir, n_ir, n_pc, n_addr, n_instr, pc_inc, target;
  logic n_req, n_vld, n_com, n_end, step_pend, n_step, start_q, taken;
  logic [1:0] flag_reg;
  logic [3:0] op;
  br_cond_t cond;
  fetch_state_t resume;
  assign op = ir[I-1 -: 4];
  assign cond = br_cond_t'(ir[I-5 -: 2]);
  // pc stays inside its slot: only the low SLOT_BITS bits advance or get replaced
  assign pc_inc = {pc[I-1:SLOT_BITS], pc[SLOT_BITS-1:0] + SLOT_BITS'(1)};
  assign target = {pc[I-1:SLOT_BITS], ir[SLOT_BITS-1:0]};
  // after a completed instruction: park if single-stepping or paused, unless a new step arrives
  assign resume = ((step_pend || pause) && !step) ? PAUSED : FETCH;
  vcpu_branch_eval u_br (.cond(cond), .flags(flag_reg), .taken(taken));
  always_comb begin
    n_state = state;
    n_pc = pc;
    n_ir = ir;
    n_req = imem_req;
    n_addr = imem_addr;
    n_instr = instr_d;
    n_vld = 1'b0;
    n_com = 1'b0;
    n_end = end_flag;
    n_step = step_pend;
    case (state)
      IDLE: if (start) begin
        n_pc = I'(select) << SLOT_BITS;
        n_end = 1'b0;
        n_step = 1'b0;
        n_state = FETCH;
      end
      FETCH: if (pause && !step && !step_pend) n_state = PAUSED;
      else begin
        n_req = 1'b1;
        n_addr = pc;
        n_step = step_pend | (step & pause);
        n_state = WAIT_ACK;
      end
      WAIT_ACK: if (imem_ack) begin
        n_ir = imem_rdata;
        n_req = 1'b0;
        n_state = ISSUE;
      end
      ISSUE: if (!dec_stall) begin
        if (op == OP_END) begin
          n_end = 1'b1;
          n_step = 1'b0;
          n_state = DONE;
        end else if (op == OP_B && cond == BR_AL) begin
          n_pc = target;
          n_step = step & pause;
          n_state = resume;
        end else if (op == OP_B) n_state = BR_WAIT;
        else begin
          n_vld = 1'b1;
          n_instr = ir;
          n_com = (op == OP_COM);
          n_pc = pc_inc;
          n_step = step & pause;
          n_state = resume;
        end
      end
      // a flag write landing this cycle is not yet in flag_reg, so wait it out
      BR_WAIT: if (pipe_idle && !flags_we) begin
        n_pc = taken ? target : pc_inc;
        n_step = step & pause;
        n_state = resume;
      end
      PAUSED: if (step) begin
        n_step = 1'b1;
        n_state = FETCH;
      end else if (!pause) n_state = FETCH;
      DONE: if (start && !start_q) n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      imem_req <= 1'b0;
      imem_addr <= '0;
      instr_d <= '0;
      instr_vld <= 1'b0;
      end_flag <= 1'b0;
      com_flag <= 1'b0;
      step_pend <= 1'b0;
      start_q <= 1'b0;
      flag_reg <= 2'b00;
    end else begin
      state <= n_state;
      pc <= n_pc;
      ir <= n_ir;
      imem_req <= n_req;
      imem_addr <= n_addr;
      instr_d <= n_instr;
      instr_vld <= n_vld;
      end_flag <= n_end;
      com_flag <= n_com;
      step_pend <= n_step;
      start_q <= start;
      flag_reg <= flags_we ? alu_flags : flag_reg;
    end
endmodule

// File: tb/tb_vcpu_fetch_ctrl.sv
// tb_vcpu_fetch_ctrl: directed tests of the fetch controller against a bench instruction memory
module tb_vcpu_fetch_ctrl;
  localparam logic [31:0] END_I = 32'hF000_0000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, step = 1'b0;
  logic [1:0] select = 2'd0;
  logic imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instr_d, pc;
  logic dec_stall = 1'b0, instr_vld, flags_we = 1'b0, pipe_idle = 1'b1, end_flag, com_flag;
  logic [1:0] alu_flags = 2'b00;
  logic [31:0] mem [4096];
  logic [31:0] addr_q [$];
  logic [31:0] instr_q [$];
  int ack_lat = 0, wcnt = 0, vld_cnt = 0, com_cnt = 0, n_chk = 0, n_fail = 0;
  vcpu_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step), .select(select),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_stall(dec_stall), .instr_d(instr_d), .instr_vld(instr_vld),
    .flags_we(flags_we), .alu_flags(alu_flags), .pipe_idle(pipe_idle),
    .pc(pc), .end_flag(end_flag), .com_flag(com_flag)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pl(input int a);
    return 32'h0100_0000 | 32'(a);
  endfunction
  always @(negedge clk)
    if (imem_req && wcnt == ack_lat) begin
      imem_ack = 1'b1;
      imem_rdata = mem[imem_addr[11:0]];
      addr_q.push_back(imem_addr);
      wcnt = 0;
    end else begin
      imem_ack = 1'b0;
      wcnt = imem_req ? wcnt + 1 : 0;
    end
  always @(posedge clk) begin
    #1;
    if (instr_vld) begin
      vld_cnt++;
      instr_q.push_back(instr_d);
    end
    if (com_flag) com_cnt++;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1);
  end
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0; dec_stall = 1'b0;
    flags_we = 1'b0; pipe_idle = 1'b1; ack_lat = 0;
    @(negedge clk);
    reset = 1'b0;
    addr_q.delete(); instr_q.delete(); vld_cnt = 0; com_cnt = 0;
  endtask
  task automatic wait_end;
    for (int i = 0; i < 100 && end_flag !== 1'b1; i++) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++; if ({imem_req, instr_vld, end_flag, com_flag} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {imem_req, instr_vld, end_flag, com_flag}); end
    n_chk++; if ({pc, imem_addr, instr_d} !== 96'd0) begin n_fail++; $display("FAIL reset_values pc=%h addr=%h instr=%h exp=0", pc, imem_addr, instr_d); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req got=%b exp=0", imem_req); end
  endtask
  task automatic test_run_slot2;
    int cyc = 0;
    do_reset;
    select = 2'd2; start = 1'b1;
    while (end_flag !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    n_chk++; if (end_flag !== 1'b1) begin n_fail++; $display("FAIL t1_end_flag got=%b exp=1", end_flag); end
    n_chk++; if (cyc != 13) begin n_fail++; $display("FAIL t1_latency got=%0d exp=13", cyc); end
    n_chk++; if (vld_cnt != 3) begin n_fail++; $display("FAIL t1_issues got=%0d exp=3", vld_cnt); end
    n_chk++; if (addr_q.size() != 4) begin n_fail++; $display("FAIL t1_fetch_count got=%0d exp=4", addr_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (addr_q.size() != 4 || addr_q[k] !== 32'h800 + 32'(k)) begin n_fail++; $display("FAIL t1_addr%0d got=%h exp=%h", k, (addr_q.size() > k) ? addr_q[k] : 32'hx, 32'h800 + 32'(k)); end
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (instr_q.size() != 3 || instr_q[k] !== pl(32'h800 + k)) begin n_fail++; $display("FAIL t1_instr%0d got=%h exp=%h", k, (instr_q.size() > k) ? instr_q[k] : 32'hx, pl(32'h800 + k)); end
    end
    n_chk++; if (pc !== 32'h803) begin n_fail++; $display("FAIL t1_pc got=%h exp=803", pc); end
    n_chk++; if (com_cnt != 0) begin n_fail++; $display("FAIL t1_com got=%0d exp=0", com_cnt); end
  endtask
  task automatic test_done_restart;
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if ({end_flag, imem_req} !== 2'b10 || addr_q.size() != 4) begin n_fail++; $display("FAIL done_hold end=%b req=%b fetches=%0d exp end=1 req=0 fetches=4", end_flag, imem_req, addr_q.size()); end
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 5 && end_flag !== 1'b0; i++) begin @(posedge clk); #1; end
    n_chk++; if (end_flag !== 1'b0) begin n_fail++; $display("FAIL restart_clear got=%b exp=0", end_flag); end
    wait_end;
    n_chk++; if (end_flag !== 1'b1 || vld_cnt != 6 || addr_q.size() != 8) begin n_fail++; $display("FAIL restart_run end=%b issues=%0d fetches=%0d exp 1/6/8", end_flag, vld_cnt, addr_q.size()); end
    @(negedge clk); start = 1'b0;
  endtask
  task automatic test_wait_stall;
    int n = 0;
    do_reset;
    ack_lat = 3; dec_stall = 1'b1; select = 2'd1; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (imem_req) begin
        n++;
        n_chk++; if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL t2_addr_stable got=%h exp=400", imem_addr); end
      end else if (n > 0) break;
    end
    n_chk++; if (n != 4) begin n_fail++; $display("FAIL t2_req_cycles got=%0d exp=4", n); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_chk++; if (instr_vld !== 1'b0 || instr_d !== 32'h0) begin n_fail++; $display("FAIL t2_stall_hold vld=%b instr=%h exp 0/0", instr_vld, instr_d); end
    end
    @(negedge clk); dec_stall = 1'b0;
    wait_end;
    n_chk++; if (end_flag !== 1'b1 || vld_cnt != 1) begin n_fail++; $display("FAIL t2_single_issue end=%b issues=%0d exp 1/1", end_flag, vld_cnt); end
    n_chk++; if (instr_d !== pl(32'h400) || instr_q.size() != 1 || instr_q[0] !== pl(32'h400)) begin n_fail++; $display("FAIL t2_instr got=%h exp=%h", instr_d, pl(32'h400)); end
  endtask
  task automatic test_branch;
    do_reset;
    mem[0] = 32'hE400_0005; mem[1] = END_I; mem[5] = END_I;
    pipe_idle = 1'b0; flags_we = 1'b1; alu_flags = 2'b01;
    @(negedge clk); flags_we = 1'b0; select = 2'd0; start = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_chk++; if (pc !== 32'h0 || imem_req !== 1'b0 || vld_cnt != 0) begin n_fail++; $display("FAIL t3_br_wait pc=%h req=%b issues=%0d exp 0/0/0", pc, imem_req, vld_cnt); end
    @(negedge clk); pipe_idle = 1'b1; flags_we = 1'b1; alu_flags = 2'b01;
    @(posedge clk); #1;
    n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL t3_we_excluded pc=%h exp=0", pc); end
    @(negedge clk); flags_we = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (pc !== 32'h5) begin n_fail++; $display("FAIL t3_taken pc=%h exp=5", pc); end
    wait_end;
    n_chk++; if (end_flag !== 1'b1 || addr_q.size() != 2 || addr_q[1] !== 32'h5 || vld_cnt != 0) begin n_fail++; $display("FAIL t3_taken_run end=%b fetches=%0d issues=%0d exp 1/2/0", end_flag, addr_q.size(), vld_cnt); end
    do_reset;
    pipe_idle = 1'b0; flags_we = 1'b1; alu_flags = 2'b10;
    @(negedge clk); flags_we = 1'b0; select = 2'd0; start = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk); pipe_idle = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (pc !== 32'h1) begin n_fail++; $display("FAIL t3_not_taken pc=%h exp=1", pc); end
    wait_end;
    n_chk++; if (end_flag !== 1'b1 || addr_q.size() != 2 || addr_q[1] !== 32'h1) begin n_fail++; $display("FAIL t3_not_taken_run end=%b fetches=%0d exp 1/2", end_flag, addr_q.size()); end
  endtask
  task automatic test_pause_step;
    do_reset;
    mem[12'hC06] = END_I;
    ack_lat = 2; select = 2'd3; start = 1'b1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin @(posedge clk); #1; end
    @(negedge clk); pause = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_chk++; if (vld_cnt != 1 || addr_q.size() != 1 || imem_req !== 1'b0 || pc !== 32'hC01) begin n_fail++; $display("FAIL t4_paused issues=%0d fetches=%0d req=%b pc=%h exp 1/1/0/c01", vld_cnt, addr_q.size(), imem_req, pc); end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      n_chk++; if (vld_cnt != s + 2 || addr_q.size() != s + 2) begin n_fail++; $display("FAIL t4_step%0d issues=%0d fetches=%0d exp=%0d", s, vld_cnt, addr_q.size(), s + 2); end
    end
    n_chk++; if (pc !== 32'hC04 || instr_q.size() != 4 || instr_q[3] !== pl(32'hC03)) begin n_fail++; $display("FAIL t4_step_pc pc=%h instr=%h exp c04/%h", pc, instr_d, pl(32'hC03)); end
    @(negedge clk); pause = 1'b0;
    wait_end;
    n_chk++; if (end_flag !== 1'b1 || vld_cnt != 6) begin n_fail++; $display("FAIL t4_resume end=%b issues=%0d exp 1/6", end_flag, vld_cnt); end
  endtask
  task automatic test_wrap_com;
    logic [31:0] exp_a [4];
    exp_a = '{32'h0, 32'h3FF, 32'h0, 32'h1};
    do_reset;
    mem[0] = 32'hE000_03FF; mem[1] = END_I;
    select = 2'd0; start = 1'b1;
    for (int i = 0; i < 20 && pc !== 32'h3FF; i++) begin @(posedge clk); #1; end
    n_chk++; if (pc !== 32'h3FF) begin n_fail++; $display("FAIL t5_branch_always pc=%h exp=3ff", pc); end
    mem[0] = 32'hD000_0123;
    wait_end;
    n_chk++; if (end_flag !== 1'b1 || addr_q.size() != 4) begin n_fail++; $display("FAIL t5_run end=%b fetches=%0d exp 1/4", end_flag, addr_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (addr_q.size() != 4 || addr_q[k] !== exp_a[k]) begin n_fail++; $display("FAIL t5_addr%0d got=%h exp=%h", k, (addr_q.size() > k) ? addr_q[k] : 32'hx, exp_a[k]); end
    end
    n_chk++; if (vld_cnt != 2 || instr_q.size() != 2 || instr_q[0] !== pl(32'h3FF) || instr_q[1] !== 32'hD000_0123) begin n_fail++; $display("FAIL t5_issues got=%0d exp=2", vld_cnt); end
    n_chk++; if (com_cnt != 1) begin n_fail++; $display("FAIL t5_com_pulse got=%0d exp=1", com_cnt); end
  endtask
  task automatic test_reset_mid_fetch;
    do_reset;
    select = 2'd1; start = 1'b1;
    for (int i = 0; i < 20 && vld_cnt != 1; i++) begin @(posedge clk); #1; end
    ack_lat = 20;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin @(posedge clk); #1; end
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h401 || instr_d !== pl(32'h400)) begin n_fail++; $display("FAIL t6_pre req=%b addr=%h instr=%h exp 1/401/%h", imem_req, imem_addr, instr_d, pl(32'h400)); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({imem_req, instr_vld, end_flag, com_flag} !== 4'b0) begin n_fail++; $display("FAIL t6_async_flags got=%b exp=0000", {imem_req, instr_vld, end_flag, com_flag}); end
    n_chk++; if ({pc, imem_addr, instr_d} !== 96'd0) begin n_fail++; $display("FAIL t6_async_values pc=%h addr=%h instr=%h exp=0", pc, imem_addr, instr_d); end
    @(negedge clk);
    reset = 1'b0; ack_lat = 0; select = 2'd2; addr_q.delete();
    for (int i = 0; i < 10 && addr_q.size() == 0; i++) begin @(posedge clk); #1; end
    n_chk++; if (addr_q.size() == 0 || addr_q[0] !== 32'h800) begin n_fail++; $display("FAIL t6_refetch got=%h exp=800", (addr_q.size() > 0) ? addr_q[0] : 32'hx); end
    wait_end;
    n_chk++; if (end_flag !== 1'b1) begin n_fail++; $display("FAIL t6_end got=%b exp=1", end_flag); end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = pl(i);
    mem[12'h803] = END_I;
    mem[12'h401] = END_I;
    test_reset;
    test_run_slot2;
    test_done_restart;
    test_wait_stall;
    test_branch;
    test_pause_step;
    test_wrap_com;
    test_reset_mid_fetch;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
